// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: issues one bus transaction per load/store,
// stalls the pipeline until it completes, and returns the extended load result.
module mem_access_unit #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_mem,
   input  logic              re_mem,
   input  logic              we_mem_mem,
   input  logic [2:0]        funct3_mem,
   input  logic [ADDR_W-1:0] alu_res_mem,
   input  logic [DATA_W-1:0] rs2_data_mem,
   input  logic              pipe_stall,
   input  logic              flush,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   output logic [7:0]        mem_req_wmask,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_rdata,
   output logic [DATA_W-1:0] dmem_mem,
   output logic [DATA_W-1:0] rw_wdata,
   output logic              mem_stall,
   output logic              misalign_mem,
   output logic [1:0]        state_dbg
);

   // Bus handshake: a request transfers on a cycle where mem_req_valid and
   // mem_req_ready are both 1; while valid is high and ready is low, we, addr,
   // wdata and wmask are held. One response (mem_resp_valid) follows each
   // accepted request, no earlier than the cycle after acceptance, and is
   // only sampled in WAIT.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [2:0]        off_q, off_d;
   logic [2:0]        f3_q, f3_d;
   logic              load_q, load_d;
   logic              flushed_q, flushed_d;
   logic              req_valid_q, req_valid_d;
   logic              req_we_q, req_we_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
   logic [7:0]        req_wmask_q, req_wmask_d;
   logic [DATA_W-1:0] dmem_q, dmem_d;

   logic              acc;
   logic              mis;
   logic              start;
   logic [2:0]        off;
   logic [1:0]        size;
   logic [7:0]        base_mask;
   logic [7:0]        lane_mask;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] lane;
   logic [DATA_W-1:0] load_val;

   always_comb begin
      off       = alu_res_mem[2:0];
      size      = funct3_mem[1:0];
      acc       = valid_mem & (re_mem | we_mem_mem);
      mis       = acc & (((size == 2'b01) & off[0])
                       | ((size == 2'b10) & (off[1:0] != 2'b00))
                       | ((size == 2'b11) & (off != 3'b000)));
      start     = acc & ~mis & ~flush;
      shifted   = rs2_data_mem << {off, 3'b000};
      base_mask = 8'h00;
      case (size)
         2'b00:   base_mask = 8'h01;
         2'b01:   base_mask = 8'h03;
         2'b10:   base_mask = 8'h0F;
         default: base_mask = 8'hFF;
      endcase
      lane_mask = base_mask << off;
   end

   // Load extraction works from the offset/size latched at issue time, since
   // the EX/MEM inputs may change once a flush kills the instruction.
   always_comb begin
      lane     = mem_resp_rdata >> {off_q, 3'b000};
      load_val = lane;
      case (f3_q)
         3'b000:  load_val = {{(DATA_W-8){lane[7]}},   lane[7:0]};
         3'b001:  load_val = {{(DATA_W-16){lane[15]}}, lane[15:0]};
         3'b010:  load_val = {{(DATA_W-32){lane[31]}}, lane[31:0]};
         3'b100:  load_val = {{(DATA_W-8){1'b0}},      lane[7:0]};
         3'b101:  load_val = {{(DATA_W-16){1'b0}},     lane[15:0]};
         3'b110:  load_val = {{(DATA_W-32){1'b0}},     lane[31:0]};
         default: load_val = lane;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      off_d       = off_q;
      f3_d        = f3_q;
      load_d      = load_q;
      flushed_d   = flushed_q;
      req_valid_d = req_valid_q;
      req_we_d    = req_we_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      req_wmask_d = req_wmask_q;
      dmem_d      = dmem_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_REQ;
               off_d       = off;
               f3_d        = funct3_mem;
               load_d      = ~we_mem_mem;
               flushed_d   = 1'b0;
               req_valid_d = 1'b1;
               req_we_d    = we_mem_mem;
               req_addr_d  = {alu_res_mem[ADDR_W-1:3], 3'b000};
               req_wdata_d = we_mem_mem ? shifted : '0;
               req_wmask_d = we_mem_mem ? lane_mask : 8'h00;
            end
         end
         S_REQ: begin
            if (flush) flushed_d = 1'b1;
            if (mem_req_ready) begin
               req_valid_d = 1'b0;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (flush) flushed_d = 1'b1;
            if (mem_resp_valid) begin
               // A killed instruction still drains the bus but never reaches DONE.
               if (flushed_q | flush) begin
                  state_d = S_IDLE;
               end else begin
                  if (load_q) dmem_d = load_val;
                  state_d = S_DONE;
               end
            end
         end
         default: begin
            if (flush | ~pipe_stall) state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      mem_stall = 1'b0;
      case (state_q)
         S_IDLE:  mem_stall = start;
         S_REQ:   mem_stall = 1'b1;
         S_WAIT:  mem_stall = 1'b1;
         default: mem_stall = 1'b0;
      endcase
      misalign_mem  = mis & (state_q == S_IDLE);
      rw_wdata      = shifted;
      mem_req_valid = req_valid_q;
      mem_req_we    = req_we_q;
      mem_req_addr  = req_addr_q;
      mem_req_wdata = req_wdata_q;
      mem_req_wmask = req_wmask_q;
      dmem_mem      = dmem_q;
      state_dbg     = state_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         off_q       <= 3'b000;
         f3_q        <= 3'b000;
         load_q      <= 1'b0;
         flushed_q   <= 1'b0;
         req_valid_q <= 1'b0;
         req_we_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_wmask_q <= 8'h00;
         dmem_q      <= '0;
      end else begin
         state_q     <= state_d;
         off_q       <= off_d;
         f3_q        <= f3_d;
         load_q      <= load_d;
         flushed_q   <= flushed_d;
         req_valid_q <= req_valid_d;
         req_we_q    <= req_we_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         req_wmask_q <= req_wmask_d;
         dmem_q      <= dmem_d;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a reactive bus slave driven per scenario, with
// expected values from a byte-level reference model of the load/store rules.
module tb_mem_access_unit;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_mem, re_mem, we_mem_mem;
   logic [2:0]  funct3_mem;
   logic [63:0] alu_res_mem, rs2_data_mem;
   logic        pipe_stall, flush;
   logic        mem_req_valid, mem_req_ready, mem_req_we;
   logic [63:0] mem_req_addr, mem_req_wdata;
   logic [7:0]  mem_req_wmask;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_rdata;
   logic [63:0] dmem_mem, rw_wdata;
   logic        mem_stall, misalign_mem;
   logic [1:0]  state_dbg;

   mem_access_unit #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk(clk), .rst(rst), .valid_mem(valid_mem), .re_mem(re_mem),
      .we_mem_mem(we_mem_mem), .funct3_mem(funct3_mem), .alu_res_mem(alu_res_mem),
      .rs2_data_mem(rs2_data_mem), .pipe_stall(pipe_stall), .flush(flush),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
      .dmem_mem(dmem_mem), .rw_wdata(rw_wdata), .mem_stall(mem_stall),
      .misalign_mem(misalign_mem), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   logic [63:0] exp_q[$];
   logic [63:0] model_dmem;

   // observations from one do_access run
   int          o_stall_cnt, o_req_cycles, o_accepts, o_done_cycles;
   logic        o_finished, o_unstable, o_end_stall, o_mis, o_req_we;
   logic [63:0] o_req_addr, o_req_wdata, o_rw_wdata, o_done_dmem;
   logic [7:0]  o_req_wmask;

   // reference model
   function automatic int ref_nbytes(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 8;
      endcase
   endfunction

   function automatic logic [63:0] ref_load(input logic [63:0] rd, input int off, input logic [2:0] f3);
      int nb;
      logic [63:0] r;
      nb = ref_nbytes(f3);
      r = '0;
      for (int i = 0; i < nb; i++)
         if (off + i < 8) r[8*i +: 8] = rd[8*(off+i) +: 8];
      if (!f3[2] && nb < 8 && r[8*nb-1])
         for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
      return r;
   endfunction

   function automatic logic [63:0] ref_wdata(input logic [63:0] rs2, input int off);
      logic [63:0] w;
      w = '0;
      for (int i = 0; i < 8; i++)
         if (i >= off) w[8*i +: 8] = rs2[8*(i-off) +: 8];
      return w;
   endfunction

   function automatic logic [7:0] ref_wmask(input logic [2:0] f3, input int off);
      logic [7:0] m;
      m = 8'h00;
      for (int i = 0; i < ref_nbytes(f3); i++)
         if (off + i < 8) m[off+i] = 1'b1;
      return m;
   endfunction

   // driver: present one instruction and act as the bus slave until the unit
   // is back in IDLE
   task automatic do_access(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] rs2,
                            input int ready_lat, input int resp_lat,
                            input logic [63:0] rdata, input logic flush_wait,
                            input int pstall_n);
      int rdy_cnt, wait_cnt, done_cnt;
      logic started, first_req;
      logic [1:0] s;
      @(negedge clk);
      o_stall_cnt = 0; o_req_cycles = 0; o_accepts = 0; o_done_cycles = 0;
      o_finished = 0; o_unstable = 0; o_end_stall = 1; o_mis = 0; o_req_we = 0;
      o_req_addr = '0; o_req_wdata = '0; o_rw_wdata = '0; o_done_dmem = 'x;
      o_req_wmask = '0;
      rdy_cnt = 0; wait_cnt = 0; done_cnt = 0; started = 0; first_req = 1;
      valid_mem = 1; re_mem = ld; we_mem_mem = st; funct3_mem = f3;
      alu_res_mem = addr; rs2_data_mem = rs2;
      for (int it = 0; it < 80; it++) begin
         s = state_dbg;
         mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
         flush = 0; pipe_stall = 0;
         if (s == ST_IDLE && started) begin
            valid_mem = 0; re_mem = 0; we_mem_mem = 0;
            #1;
            o_end_stall = mem_stall;
            o_finished = 1;
            break;
         end
         if (s == ST_REQ) begin
            if (rdy_cnt >= ready_lat) mem_req_ready = 1;
            rdy_cnt++;
            o_req_cycles++;
         end
         if (s == ST_WAIT) begin
            if (flush_wait && wait_cnt == 0) flush = 1;
            if (wait_cnt >= resp_lat) begin
               mem_resp_valid = 1;
               mem_resp_rdata = rdata;
            end
            wait_cnt++;
         end
         if (s == ST_DONE) begin
            if (done_cnt < pstall_n) pipe_stall = 1;
            done_cnt++;
         end
         #1;
         if (mem_stall) o_stall_cnt++;
         if (s == ST_IDLE) begin
            o_rw_wdata = rw_wdata;
            o_mis = misalign_mem;
         end
         if (mem_req_valid) begin
            if (first_req) begin
               o_req_we = mem_req_we; o_req_addr = mem_req_addr;
               o_req_wdata = mem_req_wdata; o_req_wmask = mem_req_wmask;
               first_req = 0;
            end else if (mem_req_we !== o_req_we || mem_req_addr !== o_req_addr ||
                         mem_req_wdata !== o_req_wdata || mem_req_wmask !== o_req_wmask) begin
               o_unstable = 1;
            end
            if (mem_req_ready) o_accepts++;
         end
         if (s == ST_DONE && done_cnt == 1) o_done_dmem = dmem_mem;
         o_done_cycles = done_cnt;
         started = 1;
         @(negedge clk);
      end
      mem_req_ready = 0; mem_resp_valid = 0; flush = 0; pipe_stall = 0;
      valid_mem = 0; re_mem = 0; we_mem_mem = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (2) @(negedge clk);
      total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
      total++; if (mem_req_valid !== 1'b0 || mem_req_we !== 1'b0) begin bad++; $display("FAIL reset_req got valid=%b we=%b exp=0", mem_req_valid, mem_req_we); end
      total++; if (mem_req_addr !== 64'h0 || mem_req_wdata !== 64'h0 || mem_req_wmask !== 8'h0) begin bad++; $display("FAIL reset_fields got addr=%h wdata=%h wmask=%h exp=0", mem_req_addr, mem_req_wdata, mem_req_wmask); end
      total++; if (dmem_mem !== 64'h0) begin bad++; $display("FAIL reset_dmem got=%h exp=0", dmem_mem); end
      total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", mem_stall); end
      model_dmem = 64'h0;
      rst = 0;
   endtask

   task automatic test_lw();
      logic [63:0] exp;
      exp = ref_load(64'h8000_0001_0000_0000, 4, 3'b010);
      do_access(1, 0, 3'b010, 64'h1004, 64'h0, 0, 0, 64'h8000_0001_0000_0000, 0, 0);
      total++; if (!o_finished) begin bad++; $display("FAIL lw_timeout got=unfinished exp=finished"); end
      total++; if (o_req_addr !== 64'h1000) begin bad++; $display("FAIL lw_addr got=%h exp=%h", o_req_addr, 64'h1000); end
      total++; if (o_req_we !== 1'b0 || o_req_wmask !== 8'h00) begin bad++; $display("FAIL lw_rd got we=%b wmask=%h exp we=0 wmask=00", o_req_we, o_req_wmask); end
      total++; if (o_stall_cnt != 3) begin bad++; $display("FAIL lw_stall got=%0d exp=3", o_stall_cnt); end
      total++; if (o_done_cycles != 1) begin bad++; $display("FAIL lw_done got=%0d exp=1", o_done_cycles); end
      total++; if (o_mis !== 1'b0) begin bad++; $display("FAIL lw_mis got=%b exp=0", o_mis); end
      total++; if (o_done_dmem !== 64'hFFFF_FFFF_8000_0001 || o_done_dmem !== exp) begin bad++; $display("FAIL lw_dmem got=%h exp=%h", o_done_dmem, exp); end
      model_dmem = exp;
   endtask

   task automatic test_sb();
      do_access(0, 1, 3'b000, 64'h2003, 64'hAB, 0, 0, {$urandom, $urandom}, 0, 0);
      total++; if (o_req_wdata !== 64'h0000_0000_AB00_0000) begin bad++; $display("FAIL sb_wdata got=%h exp=%h", o_req_wdata, 64'h0000_0000_AB00_0000); end
      total++; if (o_req_wmask !== 8'h08) begin bad++; $display("FAIL sb_wmask got=%h exp=08", o_req_wmask); end
      total++; if (o_req_we !== 1'b1 || o_req_addr !== 64'h2000) begin bad++; $display("FAIL sb_req got we=%b addr=%h exp we=1 addr=2000", o_req_we, o_req_addr); end
      total++; if (o_rw_wdata !== 64'h0000_0000_AB00_0000) begin bad++; $display("FAIL sb_rw_wdata got=%h exp=%h", o_rw_wdata, 64'h0000_0000_AB00_0000); end
      total++; if (o_done_dmem !== model_dmem || o_stall_cnt != 3) begin bad++; $display("FAIL sb_done got dmem=%h stall=%0d exp dmem=%h stall=3", o_done_dmem, o_stall_cnt, model_dmem); end
   endtask

   task automatic test_misalign();
      logic [2:0]  f3s[6];
      logic [63:0] adrs[6];
      logic        sts[6];
      f3s = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b001};
      adrs = '{64'h3001, 64'h3002, 64'h3004, 64'h3007, 64'h3003, 64'h3005};
      sts = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         valid_mem = 1; re_mem = !sts[k]; we_mem_mem = sts[k]; funct3_mem = f3s[k];
         alu_res_mem = adrs[k] ^ {$urandom_range(0, 255), 12'h000}; rs2_data_mem = {$urandom, $urandom};
         #1;
         total++; if (misalign_mem !== 1'b1 || mem_stall !== 1'b0) begin bad++; $display("FAIL mis_flag k=%0d got mis=%b stall=%b exp mis=1 stall=0", k, misalign_mem, mem_stall); end
         @(negedge clk);
         total++; if (mem_req_valid !== 1'b0 || state_dbg !== ST_IDLE) begin bad++; $display("FAIL mis_noreq k=%0d got valid=%b state=%0d exp valid=0 state=0", k, mem_req_valid, state_dbg); end
         valid_mem = 0; re_mem = 0; we_mem_mem = 0;
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] rd;
      rd = {$urandom, $urandom};
      do_access(1, 0, 3'b011, 64'h5008, 64'h0, 3, 0, rd, 0, 0);
      total++; if (o_unstable !== 1'b0) begin bad++; $display("FAIL bp_stable got=unstable exp=stable"); end
      total++; if (o_req_cycles != 4 || o_accepts != 1) begin bad++; $display("FAIL bp_req got cycles=%0d accepts=%0d exp cycles=4 accepts=1", o_req_cycles, o_accepts); end
      total++; if (o_stall_cnt != 6) begin bad++; $display("FAIL bp_stall got=%0d exp=6", o_stall_cnt); end
      total++; if (o_done_dmem !== rd) begin bad++; $display("FAIL bp_dmem got=%h exp=%h", o_done_dmem, rd); end
      model_dmem = rd;
   endtask

   task automatic test_flush_wait();
      do_access(1, 0, 3'b100, 64'h6005, 64'h0, 0, 2, 64'h0000_FF00_0000_0000, 1, 0);
      total++; if (!o_finished || o_done_cycles != 0) begin bad++; $display("FAIL fl_nodone got finished=%b done=%0d exp finished=1 done=0", o_finished, o_done_cycles); end
      total++; if (dmem_mem !== model_dmem) begin bad++; $display("FAIL fl_dmem got=%h exp=%h", dmem_mem, model_dmem); end
      total++; if (o_stall_cnt != 5 || o_end_stall !== 1'b0) begin bad++; $display("FAIL fl_stall got cnt=%0d end=%b exp cnt=5 end=0", o_stall_cnt, o_end_stall); end
   endtask

   task automatic test_pipe_stall_done();
      do_access(1, 0, 3'b101, 64'h4002, 64'h0, 0, 0, 64'h0000_0000_8001_0000, 0, 2);
      total++; if (o_done_cycles != 3) begin bad++; $display("FAIL ps_done got=%0d exp=3", o_done_cycles); end
      total++; if (o_accepts != 1 || o_req_cycles != 1) begin bad++; $display("FAIL ps_reissue got accepts=%0d reqcyc=%0d exp 1/1", o_accepts, o_req_cycles); end
      total++; if (o_done_dmem !== 64'h8001 || dmem_mem !== 64'h8001) begin bad++; $display("FAIL ps_dmem got=%h/%h exp=%h", o_done_dmem, dmem_mem, 64'h8001); end
      model_dmem = 64'h8001;
   endtask

   task automatic test_flush_idle_and_nonmem();
      @(negedge clk);
      valid_mem = 1; re_mem = 1; we_mem_mem = 0; funct3_mem = 3'b011;
      alu_res_mem = 64'h7000; flush = 1;
      #1;
      total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL fli_stall got=%b exp=0", mem_stall); end
      @(negedge clk);
      total++; if (mem_req_valid !== 1'b0 || state_dbg !== ST_IDLE) begin bad++; $display("FAIL fli_noreq got valid=%b state=%0d exp 0/0", mem_req_valid, state_dbg); end
      flush = 0; re_mem = 0;
      #1;
      total++; if (mem_stall !== 1'b0 || misalign_mem !== 1'b0) begin bad++; $display("FAIL nonmem_stall got stall=%b mis=%b exp 0/0", mem_stall, misalign_mem); end
      @(negedge clk);
      total++; if (mem_req_valid !== 1'b0 || dmem_mem !== model_dmem) begin bad++; $display("FAIL nonmem_hold got valid=%b dmem=%h exp valid=0 dmem=%h", mem_req_valid, dmem_mem, model_dmem); end
      valid_mem = 0;
   endtask

   task automatic test_random();
      logic        ld, st;
      logic [2:0]  f3;
      logic [63:0] addr, rs2, rd, exp;
      int          nb, off, rl, pl, ps;
      for (int n = 0; n < 40; n++) begin
         st = ($urandom_range(0, 1) == 1);
         ld = st ? ($urandom_range(0, 1) == 1) : 1'b1;
         f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
         nb = ref_nbytes(f3);
         off = ($urandom_range(0, 7) / nb) * nb;
         addr = {$urandom, $urandom};
         addr[2:0] = 3'(off);
         rs2 = {$urandom, $urandom};
         rd = {$urandom, $urandom};
         rl = $urandom_range(0, 3); pl = $urandom_range(0, 3); ps = $urandom_range(0, 2);
         exp = st ? model_dmem : ref_load(rd, off, f3);
         exp_q.push_back(exp);
         do_access(ld, st, f3, addr, rs2, rl, pl, rd, 0, ps);
         exp = exp_q.pop_front();
         total++; if (o_done_dmem !== exp) begin bad++; $display("FAIL rnd_dmem n=%0d f3=%0d off=%0d got=%h exp=%h", n, f3, off, o_done_dmem, exp); end
         total++; if (o_req_addr !== {addr[63:3], 3'b000} || o_req_we !== st) begin bad++; $display("FAIL rnd_req n=%0d got addr=%h we=%b exp addr=%h we=%b", n, o_req_addr, o_req_we, {addr[63:3], 3'b000}, st); end
         if (st) begin
            total++; if (o_req_wdata !== ref_wdata(rs2, off) || o_req_wmask !== ref_wmask(f3, off)) begin bad++; $display("FAIL rnd_lanes n=%0d got wdata=%h wmask=%h exp wdata=%h wmask=%h", n, o_req_wdata, o_req_wmask, ref_wdata(rs2, off), ref_wmask(f3, off)); end
         end else begin
            total++; if (o_req_wmask !== 8'h00) begin bad++; $display("FAIL rnd_rdmask n=%0d got=%h exp=00", n, o_req_wmask); end
         end
         total++; if (o_rw_wdata !== ref_wdata(rs2, off)) begin bad++; $display("FAIL rnd_rw n=%0d got=%h exp=%h", n, o_rw_wdata, ref_wdata(rs2, off)); end
         total++; if (o_stall_cnt != 3 + rl + pl || o_done_cycles != ps + 1 || o_unstable) begin bad++; $display("FAIL rnd_timing n=%0d got stall=%0d done=%0d unstable=%b exp stall=%0d done=%0d", n, o_stall_cnt, o_done_cycles, o_unstable, 3 + rl + pl, ps + 1); end
         model_dmem = exp;
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      valid_mem = 1; re_mem = 1; we_mem_mem = 0; funct3_mem = 3'b011;
      alu_res_mem = 64'h8800; mem_req_ready = 0;
      @(negedge clk);
      total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL rm_req got=%b exp=1", mem_req_valid); end
      rst = 1; valid_mem = 0; re_mem = 0;
      @(negedge clk);
      total++; if (state_dbg !== ST_IDLE || mem_req_valid !== 1'b0 || dmem_mem !== 64'h0) begin bad++; $display("FAIL rm_idle got state=%0d valid=%b dmem=%h exp 0/0/0", state_dbg, mem_req_valid, dmem_mem); end
      rst = 0;
      model_dmem = 64'h0;
   endtask

   initial begin
      rst = 1; valid_mem = 0; re_mem = 0; we_mem_mem = 0; funct3_mem = 3'b000;
      alu_res_mem = '0; rs2_data_mem = '0; pipe_stall = 0; flush = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
      test_reset();
      test_lw();
      test_sb();
      test_misalign();
      test_backpressure();
      test_flush_wait();
      test_pipe_stall_done();
      test_flush_idle_and_nonmem();
      test_random();
      test_reset_mid();
      test_lw();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access engine of the 64-bit RISC-V 5-stage pipeline.
- Sits between the EX/MEM latch and the MEM/WB latch.
- Takes the address (alu_res_mem), the store data (rs2_data_mem) and the access type.
- Runs one request/response transaction on the data-memory bus and stalls the pipeline until the transaction completes.
- Produces the load result dmem_mem and the lane-aligned store data rw_wdata, both consumed by the MEM/WB latch.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, bus and register data width; fixed at 64 (8 byte lanes).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_mem  in  1  MEM stage holds a valid instruction.
- re_mem  in  1  instruction is a load.
- we_mem_mem  in  1  instruction is a store.
- funct3_mem  in  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- alu_res_mem  in  64  byte address.
- rs2_data_mem  in  64  store source data.
- pipe_stall  in  1  downstream/global stall that holds the MEM stage.
- flush  in  1  kill the MEM-stage instruction.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts the request.
- mem_req_we  out  1  1 = write.
- mem_req_addr  out  64  8-byte-aligned address ({addr[63:3],3'b0}).
- mem_req_wdata  out  64  store data shifted into its lanes.
- mem_req_wmask  out  8  byte-lane write enables; 0 for reads.
- mem_resp_valid  in  1  read data / write acknowledge valid.
- mem_resp_rdata  in  64  read data.
- dmem_mem  out  64  extended load result.
- rw_wdata  out  64  lane-shifted store data, forwarded to mem_wdata_wb.
- mem_stall  out  1  stall request to the IF through MEM latches.
- misalign_mem  out  1  misaligned access detected; no bus request is issued.

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset values: state = IDLE; all registered outputs = 0 (mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask, dmem_mem); internal latches = 0.
- Access: acc = valid_mem & (re_mem | we_mem_mem). A store wins if both re_mem and we_mem_mem are set.
- Misalignment: mis = acc & ((H & addr[0]) | (W & addr[1:0] != 0) | (D & addr[2:0] != 0)).
- misalign_mem = mis in IDLE, combinational. On mis, no request is issued and mem_stall = 0.
- IDLE:
  - If acc & !mis & !flush: latch addr[2:0], funct3 and type; drive request registers; go to REQ.
  - mem_stall = acc & !mis & !flush, combinational.
- REQ:
  - mem_req_valid = 1.
  - addr, we, wdata and wmask stay stable until mem_req_ready = 1, then go to WAIT.
  - mem_stall = 1.
- WAIT:
  - On mem_resp_valid, capture the load result into dmem_mem (stores leave dmem_mem unchanged) and go to DONE.
  - mem_stall = 1.
  - mem_resp_valid is ignored in every other state. A response arrives no earlier than the cycle after acceptance.
- DONE:
  - mem_stall = 0, so the MEM/WB latch captures dmem_mem this cycle.
  - If pipe_stall = 1, remain in DONE (no re-issue). Otherwise go to IDLE.
- Minimum latency with ready = 1 and response on the next cycle: 3 stall cycles, then 1 DONE cycle.
- Store lanes:
  - shift = 8*addr[2:0].
  - wdata = rs2 << shift.
  - wmask = (B: 8'h01, H: 8'h03, W: 8'h0F, D: 8'hFF) << addr[2:0].
  - rw_wdata = the same shifted data, combinational from the current inputs.
- Load extraction:
  - lane = rdata >> (8*latched addr[2:0]).
  - B/H/W are sign-extended from bit 7/15/31.
  - BU/HU/WU are zero-extended.
  - D passes through.
  - funct3 111 on a load is treated as D.
- Flush:
  - Flush in IDLE: no request is issued.
  - Flush in REQ/WAIT: the bus transaction runs to completion (protocol is never abandoned) and mem_stall stays 1. The response is discarded (dmem_mem not updated) and the FSM goes WAIT → IDLE, skipping DONE.
  - Flush in DONE: go to IDLE.
- A non-memory instruction passes with mem_stall = 0 and dmem_mem holding its previous value.
- Reset mid-transaction returns to IDLE immediately. The bus slave is reset by the same rst.

Test Plan:
- LW, addr 0x1004, rdata 0x8000_0001_0000_0000 → mem_req_addr 0x1000; stall asserted for 3 cycles; DONE dmem_mem = 0xFFFF_FFFF_8000_0001.
- SB, addr 0x2003, rs2 0xAB → mem_req_wdata 0x0000_0000_AB00_0000; wmask 8'h08; mem_req_we = 1; rw_wdata equals the shifted data.
- LH, addr 0x3001 → misalign_mem = 1; mem_req_valid stays 0; mem_stall = 0.
- LD with mem_req_ready low for 3 cycles → req fields stable throughout; state goes to WAIT only on ready; total stall 6 cycles.
- LBU in WAIT with flush = 1, then resp rdata 0xFF → dmem_mem unchanged; FSM goes to IDLE without DONE; mem_stall drops after the response.
- LHU completes while pipe_stall = 1 for 2 cycles → FSM stays in DONE, no second request; dmem_mem = 0x0000_0000_0000_8001 for rdata lane 0x8001.
